// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Oversampling UART receiver. The serial line is synchronised, then each bit
//   is sampled on ticks 7, 8 and 9 of its 16 tick_16x periods, and a 2-of-3
//   majority vote decides the bit value. A received word is held in rx_data
//   with a valid/ready handshake. Framing errors and overruns are reported as
//   single-cycle pulses.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   tick_16x   in   single-cycle strobe at 16x the baud rate
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  [DATA_BITS-1:0] last received word
//   rx_valid   out  rx_data holds an unconsumed word
//   rx_ready   in   consumer takes rx_data when high together with rx_valid
//   frame_err  out  one-cycle pulse when the stop bit votes low
//   overrun    out  one-cycle pulse when a word lands on an unconsumed word
//   busy       out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t                 state_q,     state_d;
  logic                   rx_meta_q,   rx_meta_d;
  logic                   rx_s_q,      rx_s_d;
  logic [3:0]             s_cnt_q,     s_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q,     shift_d;
  logic [2:0]             samp_q,      samp_d;
  logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q,   overrun_d;

  logic [3:0]             tick_idx;
  logic                   maj_bit;
  logic                   maj_stop;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // s_cnt holds the index of the last tick already handled in the current
  // bit, so the tick being processed now is s_cnt + 1 (wrapping 15 -> 0).
  // The stop bit is decided on tick 9, before samp_q has captured the third
  // sample, so its vote uses the live synchronised line instead.
  always_comb begin
    tick_idx = s_cnt_q + 4'd1;
    maj_bit  = majority(samp_q[0], samp_q[1], samp_q[2]);
    maj_stop = majority(samp_q[0], samp_q[1], rx_s_q);
  end

  // Next-state logic for every flop: synchroniser, bit timing, shifting,
  // stop-bit decision and the consumer handshake. Pulses default low so
  // they only ever last a single clock.
  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    s_cnt_d     = s_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // The tick that first sees the line low is tick 0 of the start bit.
        if (tick_16x && !rx_s_q) begin
          state_d = START;
          s_cnt_d = 4'd0;
        end
      end

      START, DATA, STOP: begin
        if (tick_16x) begin
          s_cnt_d = tick_idx;
          if (tick_idx == 4'd7) samp_d[0] = rx_s_q;
          if (tick_idx == 4'd8) samp_d[1] = rx_s_q;
          if (tick_idx == 4'd9) samp_d[2] = rx_s_q;

          if (state_q == START && tick_idx == 4'd15) begin
            // A start bit that does not vote low was line noise.
            if (!maj_bit) begin
              state_d   = DATA;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end

          if (state_q == DATA && tick_idx == 4'd15) begin
            shift_d[bit_idx_q] = maj_bit;
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
          end

          if (state_q == STOP && tick_idx == 4'd9) begin
            if (maj_stop) begin
              // A new word always wins; it is only an overrun when the
              // old word is neither consumed earlier nor on this very edge.
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              overrun_d  = rx_valid_q && !rx_ready;
              state_d    = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end
        end
      end

      BREAK: begin
        // Leave as soon as the line is back high, without waiting for a tick,
        // so the next start edge is not missed.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single register stage for the whole receiver, synchronous reset. The
  // synchroniser resets high so a stale low cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      s_cnt_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      s_cnt_q     <= s_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
